cs_microsequencer: RTL and testbench
====================================

Name: cs_microsequencer

Overview:
- Sequential core of the control section. Holds the Control Store Address Register (CSAR) and generates the incremented address (CSAI).
- Latches the ALU condition codes (PSR n/z/v/c). Evaluates the microinstruction COND field to drive the 2-bit selection of the control-store address mux.
- Closes the loop: CSAI and selection go to the address mux; the mux output returns here and is registered into CSAR, which addresses the control store.
- Stalls CSAR while a microinstruction's memory access is pending.

Parameters:
ADDR_LENGTH, 11, control store address width (CSAR, CSAI, next address)
COND_LENGTH, 3, width of the MIR COND field
SELECTION_LENGTH, 2, address-mux selection width
FLAG_LENGTH, 4, PSR width: [3]=n [2]=z [1]=v [0]=c
TIMEOUT_CYCLES, 255, stalled cycles before forced advance (optional feature only; max 255)

Ports:
CS_MICROSEQUENCER_CLOCK_50  in  1  system clock, rising edge
CS_MICROSEQUENCER_RESET_InLow  in  1  asynchronous, active-low reset
CS_MICROSEQUENCER_NextAddr_InBUS  in  ADDR_LENGTH  next address from the address mux
CS_MICROSEQUENCER_MIR_COND_InBUS  in  COND_LENGTH  COND field of the current microinstruction
CS_MICROSEQUENCER_MIR_RD_In  in  1  microinstruction requests a memory read
CS_MICROSEQUENCER_MIR_WR_In  in  1  microinstruction requests a memory write
CS_MICROSEQUENCER_MemReady_In  in  1  memory access complete (level, sampled at the clock edge)
CS_MICROSEQUENCER_ALU_SetCC_In  in  1  current ALU operation updates the condition codes
CS_MICROSEQUENCER_ALU_Flags_InBUS  in  FLAG_LENGTH  n,z,v,c from the ALU
CS_MICROSEQUENCER_IR13_In  in  1  IR bit 13 (immediate flag)
CS_MICROSEQUENCER_CSAR_OutBUS  out  ADDR_LENGTH  registered control store address
CS_MICROSEQUENCER_CSAI_OutBUS  out  ADDR_LENGTH  CSAR+1, to the address mux
CS_MICROSEQUENCER_Selection_OutBUS  out  SELECTION_LENGTH  to the address mux: 00 CSAI, 01 MIR jump, 10 decode
CS_MICROSEQUENCER_PSR_OutBUS  out  FLAG_LENGTH  registered condition codes
CS_MICROSEQUENCER_Stall_Out  out  1  CSAR held this cycle

Behaviour:
- Reset (asynchronous, RESET_InLow=0): CSAR=0 and PSR=0 immediately; CSAI=1. Stall and Selection follow their combinational equations. Reset during a stall abandons the access; CSAR=0 on release.
- CSAI = CSAR+1, combinational, modulo 2^ADDR_LENGTH (0x7FF -> 0x000).
- Stall = (MIR_RD | MIR_WR) & ~MemReady, combinational. RD and WR both high count as one access.
- CSAR update at each rising edge:
  - Stall=0: CSAR <= NextAddr_InBUS.
  - Stall=1: CSAR holds.
- Zero-wait access: MemReady high in the same cycle as RD/WR means no stall.
- PSR update at each rising edge: PSR <= ALU_Flags only when ALU_SetCC=1 and Stall=0; otherwise PSR holds.
- Selection, combinational from COND and the registered PSR:
  - 000 -> 00
  - 001 -> n?01:00
  - 010 -> z?01:00
  - 011 -> v?01:00
  - 100 -> c?01:00
  - 101 -> IR13?01:00
  - 110 -> 01
  - 111 -> 10
- Selection never produces 11.
- Simultaneous SetCC and flag branch in the same microinstruction: the branch uses the old PSR; the new flags are visible from the next microinstruction.
- Latency:
  - NextAddr -> CSAR: 1 edge when not stalled.
  - Flags -> branch decision: 1 edge.

Optional Feature:
CS_MICROSEQUENCER_STALL_TIMEOUT_EN
- Defined:
  - Adds an 8-bit wait counter and output port CS_MICROSEQUENCER_Timeout_Out (1 bit).
  - The counter increments on each edge with Stall=1 and clears on each edge with Stall=0.
  - When the counter equals TIMEOUT_CYCLES while Stall=1, the effective stall is forced to 0 that cycle: CSAR advances, a pending SetCC is applied, the counter clears, and Timeout_Out is set.
  - Timeout_Out is sticky, cleared only by reset. Reset clears the counter and Timeout_Out.
- Undefined: no counter and no port; a stall lasts until MemReady.

Test Plan:
1. Async reset: with CSAR=0x123, drive RESET_InLow low mid-cycle -> CSAR=0x000, PSR=0x0, CSAI=0x001 before the next edge.
2. Sequential run: COND=000, NextAddr looped from CSAI, start CSAR=0x7FE -> CSAR 0x7FF then 0x000; CSAI wraps 0x000 -> 0x001.
3. Flag branch: PSR=0000, COND=010 -> Selection=00. Same cycle SetCC=1, Flags=0100 -> still 00. Next cycle COND=010 -> 01, PSR=0100.
4. Fixed conditions: COND=101 with IR13=1 -> 01, IR13=0 -> 00; COND=110 -> 01; COND=111 -> 10; COND=100 with c=1 -> 01.
5. Memory wait: MIR_RD=1, MemReady=0 for 3 cycles, then 1, NextAddr=0x040 -> Stall high 3 cycles, CSAR unchanged 3 edges, 0x040 on the 4th edge. SetCC=1/Flags=1111 during the stall leaves PSR unchanged until the ready cycle.
6. Timeout (macro defined, TIMEOUT_CYCLES=4): MIR_WR=1, MemReady stuck low -> CSAR advances on the 5th edge, Timeout_Out=1 and stays 1 through later normal cycles until reset.

Source files
------------

// File: rtl/cs_microsequencer_if.sv
// ============================================================================
// Module      : cs_microsequencer_if
// Description : Bus bundle between the control section and the microsequencer.
//               Timeout_Out exists only with CS_MICROSEQUENCER_STALL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cs_microsequencer_if #(
  parameter int ADDR_LENGTH      = 11,
  parameter int COND_LENGTH      = 3,
  parameter int SELECTION_LENGTH = 2,
  parameter int FLAG_LENGTH      = 4
);
  logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_NextAddr_InBUS;
  logic [COND_LENGTH-1:0]      CS_MICROSEQUENCER_MIR_COND_InBUS;
  logic                        CS_MICROSEQUENCER_MIR_RD_In;
  logic                        CS_MICROSEQUENCER_MIR_WR_In;
  logic                        CS_MICROSEQUENCER_MemReady_In;
  logic                        CS_MICROSEQUENCER_ALU_SetCC_In;
  logic [FLAG_LENGTH-1:0]      CS_MICROSEQUENCER_ALU_Flags_InBUS;
  logic                        CS_MICROSEQUENCER_IR13_In;
  logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_CSAR_OutBUS;
  logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_CSAI_OutBUS;
  logic [SELECTION_LENGTH-1:0] CS_MICROSEQUENCER_Selection_OutBUS;
  logic [FLAG_LENGTH-1:0]      CS_MICROSEQUENCER_PSR_OutBUS;
  logic                        CS_MICROSEQUENCER_Stall_Out;
`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
  logic                        CS_MICROSEQUENCER_Timeout_Out;
`endif

  // Control section side: supplies microinstruction fields, ALU flags, mux output
  modport master (
    output CS_MICROSEQUENCER_NextAddr_InBUS,
    output CS_MICROSEQUENCER_MIR_COND_InBUS,
    output CS_MICROSEQUENCER_MIR_RD_In,
    output CS_MICROSEQUENCER_MIR_WR_In,
    output CS_MICROSEQUENCER_MemReady_In,
    output CS_MICROSEQUENCER_ALU_SetCC_In,
    output CS_MICROSEQUENCER_ALU_Flags_InBUS,
    output CS_MICROSEQUENCER_IR13_In,
    input  CS_MICROSEQUENCER_CSAR_OutBUS,
    input  CS_MICROSEQUENCER_CSAI_OutBUS,
    input  CS_MICROSEQUENCER_Selection_OutBUS,
    input  CS_MICROSEQUENCER_PSR_OutBUS,
`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
    input  CS_MICROSEQUENCER_Timeout_Out,
`endif
    input  CS_MICROSEQUENCER_Stall_Out
  );

  modport slave (
    input  CS_MICROSEQUENCER_NextAddr_InBUS,
    input  CS_MICROSEQUENCER_MIR_COND_InBUS,
    input  CS_MICROSEQUENCER_MIR_RD_In,
    input  CS_MICROSEQUENCER_MIR_WR_In,
    input  CS_MICROSEQUENCER_MemReady_In,
    input  CS_MICROSEQUENCER_ALU_SetCC_In,
    input  CS_MICROSEQUENCER_ALU_Flags_InBUS,
    input  CS_MICROSEQUENCER_IR13_In,
    output CS_MICROSEQUENCER_CSAR_OutBUS,
    output CS_MICROSEQUENCER_CSAI_OutBUS,
    output CS_MICROSEQUENCER_Selection_OutBUS,
    output CS_MICROSEQUENCER_PSR_OutBUS,
`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
    output CS_MICROSEQUENCER_Timeout_Out,
`endif
    output CS_MICROSEQUENCER_Stall_Out
  );
endinterface

`default_nettype wire

// File: rtl/cs_microsequencer.sv
// ============================================================================
// Module      : cs_microsequencer
// Description : CSAR/CSAI, PSR latch, COND evaluation and memory-wait stall.
//               Optional stall watchdog: CS_MICROSEQUENCER_STALL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_microsequencer #(
  parameter int ADDR_LENGTH      = 11,
  parameter int COND_LENGTH      = 3,
  parameter int SELECTION_LENGTH = 2,
`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES   = 255,
`endif
  parameter int FLAG_LENGTH      = 4
) (
  input  wire logic           CS_MICROSEQUENCER_CLOCK_50,
  input  wire logic           CS_MICROSEQUENCER_RESET_InLow,
  cs_microsequencer_if.slave  bus
);

  localparam logic [SELECTION_LENGTH-1:0] c_SEL_CSAI   = SELECTION_LENGTH'(0);
  localparam logic [SELECTION_LENGTH-1:0] c_SEL_JUMP   = SELECTION_LENGTH'(1);
  localparam logic [SELECTION_LENGTH-1:0] c_SEL_DECODE = SELECTION_LENGTH'(2);

  logic [ADDR_LENGTH-1:0]      r_csar;
  logic [FLAG_LENGTH-1:0]      r_psr;
  logic                        w_stall_raw;
  logic                        w_stall;
  logic [SELECTION_LENGTH-1:0] w_sel;

  // RD and WR together are a single access; ready in the same cycle is zero-wait
  assign w_stall_raw = (bus.CS_MICROSEQUENCER_MIR_RD_In | bus.CS_MICROSEQUENCER_MIR_WR_In)
                       & ~bus.CS_MICROSEQUENCER_MemReady_In;

`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_timeout_hit;

  assign w_timeout_hit = w_stall_raw && (r_wait_cnt == 8'(TIMEOUT_CYCLES));
  assign w_stall       = w_stall_raw & ~w_timeout_hit;

  always_ff @(posedge CS_MICROSEQUENCER_CLOCK_50 or negedge CS_MICROSEQUENCER_RESET_InLow) begin
    if (!CS_MICROSEQUENCER_RESET_InLow) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_stall ? r_wait_cnt + 8'd1 : 8'd0;
      if (w_timeout_hit)
        r_timeout <= 1'b1;
    end
  end

  assign bus.CS_MICROSEQUENCER_Timeout_Out = r_timeout;
`else
  assign w_stall = w_stall_raw;
`endif

  always_ff @(posedge CS_MICROSEQUENCER_CLOCK_50 or negedge CS_MICROSEQUENCER_RESET_InLow) begin
    if (!CS_MICROSEQUENCER_RESET_InLow) begin
      r_csar <= '0;
      r_psr  <= '0;
    end else if (!w_stall) begin
      r_csar <= bus.CS_MICROSEQUENCER_NextAddr_InBUS;
      if (bus.CS_MICROSEQUENCER_ALU_SetCC_In)
        r_psr <= bus.CS_MICROSEQUENCER_ALU_Flags_InBUS;
    end
  end

  // Branches look at the registered PSR, so a same-cycle SetCC is seen one microinstruction later
  always_comb begin
    w_sel = c_SEL_CSAI;
    case (bus.CS_MICROSEQUENCER_MIR_COND_InBUS)
      COND_LENGTH'(0): w_sel = c_SEL_CSAI;
      COND_LENGTH'(1): w_sel = r_psr[3] ? c_SEL_JUMP : c_SEL_CSAI;
      COND_LENGTH'(2): w_sel = r_psr[2] ? c_SEL_JUMP : c_SEL_CSAI;
      COND_LENGTH'(3): w_sel = r_psr[1] ? c_SEL_JUMP : c_SEL_CSAI;
      COND_LENGTH'(4): w_sel = r_psr[0] ? c_SEL_JUMP : c_SEL_CSAI;
      COND_LENGTH'(5): w_sel = bus.CS_MICROSEQUENCER_IR13_In ? c_SEL_JUMP : c_SEL_CSAI;
      COND_LENGTH'(6): w_sel = c_SEL_JUMP;
      COND_LENGTH'(7): w_sel = c_SEL_DECODE;
      default:         w_sel = c_SEL_CSAI;
    endcase
  end

  assign bus.CS_MICROSEQUENCER_CSAR_OutBUS      = r_csar;
  assign bus.CS_MICROSEQUENCER_CSAI_OutBUS      = r_csar + ADDR_LENGTH'(1);
  assign bus.CS_MICROSEQUENCER_Selection_OutBUS = w_sel;
  assign bus.CS_MICROSEQUENCER_PSR_OutBUS       = r_psr;
  assign bus.CS_MICROSEQUENCER_Stall_Out        = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_cs_microsequencer.sv
// ============================================================================
// Module      : tb_cs_microsequencer
// Description : Directed self-checking bench for cs_microsequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_microsequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cs_microsequencer_if #(
    .ADDR_LENGTH(11), .COND_LENGTH(3), .SELECTION_LENGTH(2), .FLAG_LENGTH(4)
  ) bus ();

  cs_microsequencer #(
    .ADDR_LENGTH      (11),
    .COND_LENGTH      (3),
    .SELECTION_LENGTH (2),
`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
    .TIMEOUT_CYCLES   (4),
`endif
    .FLAG_LENGTH      (4)
  ) dut (
    .CS_MICROSEQUENCER_CLOCK_50    (clk),
    .CS_MICROSEQUENCER_RESET_InLow (rst_n),
    .bus                           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS  = 11'h000;
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS  = 3'b000;
    bus.CS_MICROSEQUENCER_MIR_RD_In       = 1'b0;
    bus.CS_MICROSEQUENCER_MIR_WR_In       = 1'b0;
    bus.CS_MICROSEQUENCER_MemReady_In     = 1'b0;
    bus.CS_MICROSEQUENCER_ALU_SetCC_In    = 1'b0;
    bus.CS_MICROSEQUENCER_ALU_Flags_InBUS = 4'h0;
    bus.CS_MICROSEQUENCER_IR13_In         = 1'b0;
    #12;
    check_eq("rst_csar",  32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h000);
    check_eq("rst_csai",  32'(bus.CS_MICROSEQUENCER_CSAI_OutBUS), 32'h001);
    check_eq("rst_psr",   32'(bus.CS_MICROSEQUENCER_PSR_OutBUS),  32'h0);
    check_eq("rst_stall", 32'(bus.CS_MICROSEQUENCER_Stall_Out),   32'h0);
    check_eq("rst_sel",   32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    rst_n = 1'b1;

    // Async reset mid-cycle from CSAR=0x123 and a non-zero PSR
    bus.CS_MICROSEQUENCER_NextAddr_InBUS  = 11'h123;
    bus.CS_MICROSEQUENCER_ALU_SetCC_In    = 1'b1;
    bus.CS_MICROSEQUENCER_ALU_Flags_InBUS = 4'hA;
    step();
    check_eq("load_csar", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h123);
    check_eq("load_psr",  32'(bus.CS_MICROSEQUENCER_PSR_OutBUS),  32'hA);
    bus.CS_MICROSEQUENCER_ALU_SetCC_In = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_csar", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h000);
    check_eq("arst_psr",  32'(bus.CS_MICROSEQUENCER_PSR_OutBUS),  32'h0);
    check_eq("arst_csai", 32'(bus.CS_MICROSEQUENCER_CSAI_OutBUS), 32'h001);
    #1 rst_n = 1'b1;

    // Sequential run across the address wrap
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h7FE;
    step();
    check_eq("seq_csar0", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h7FE);
    check_eq("seq_csai0", 32'(bus.CS_MICROSEQUENCER_CSAI_OutBUS), 32'h7FF);
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h7FF;
    step();
    check_eq("seq_csar1", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h7FF);
    check_eq("seq_csai1", 32'(bus.CS_MICROSEQUENCER_CSAI_OutBUS), 32'h000);
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h000;
    step();
    check_eq("seq_csar2", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h000);
    check_eq("seq_csai2", 32'(bus.CS_MICROSEQUENCER_CSAI_OutBUS), 32'h001);

    // Flag branch uses old PSR when SetCC is in the same microinstruction
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h010;
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b010;
    #1 check_eq("z_clear_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    bus.CS_MICROSEQUENCER_ALU_SetCC_In    = 1'b1;
    bus.CS_MICROSEQUENCER_ALU_Flags_InBUS = 4'b0100;
    #1 check_eq("z_samecyc_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    step();
    bus.CS_MICROSEQUENCER_ALU_SetCC_In = 1'b0;
    #1;
    check_eq("z_next_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h1);
    check_eq("z_next_psr", 32'(bus.CS_MICROSEQUENCER_PSR_OutBUS), 32'h4);

    // Fixed and flag conditions with PSR=0100
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b001;
    #1 check_eq("n_clear_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b101;
    bus.CS_MICROSEQUENCER_IR13_In        = 1'b1;
    #1 check_eq("ir13_1_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h1);
    bus.CS_MICROSEQUENCER_IR13_In = 1'b0;
    #1 check_eq("ir13_0_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b110;
    #1 check_eq("jump_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h1);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b111;
    #1 check_eq("decode_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h2);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b100;
    #1 check_eq("c_clear_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    bus.CS_MICROSEQUENCER_ALU_SetCC_In    = 1'b1;
    bus.CS_MICROSEQUENCER_ALU_Flags_InBUS = 4'b0001;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS  = 11'h020;
    step();
    bus.CS_MICROSEQUENCER_ALU_SetCC_In = 1'b0;
    #1;
    check_eq("c_set_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h1);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b011;
    #1 check_eq("v_clear_sel", 32'(bus.CS_MICROSEQUENCER_Selection_OutBUS), 32'h0);
    bus.CS_MICROSEQUENCER_MIR_COND_InBUS = 3'b000;

    // Memory wait: three stalled edges, then ready
    bus.CS_MICROSEQUENCER_MIR_RD_In       = 1'b1;
    bus.CS_MICROSEQUENCER_MemReady_In     = 1'b0;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS  = 11'h040;
    bus.CS_MICROSEQUENCER_ALU_SetCC_In    = 1'b1;
    bus.CS_MICROSEQUENCER_ALU_Flags_InBUS = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("wait_stall%0d", i), 32'(bus.CS_MICROSEQUENCER_Stall_Out), 32'h1);
      step();
      check_eq($sformatf("wait_csar%0d", i), 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h020);
      check_eq($sformatf("wait_psr%0d", i),  32'(bus.CS_MICROSEQUENCER_PSR_OutBUS),  32'h1);
    end
    bus.CS_MICROSEQUENCER_MemReady_In = 1'b1;
    #1 check_eq("ready_stall", 32'(bus.CS_MICROSEQUENCER_Stall_Out), 32'h0);
    step();
    check_eq("ready_csar", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h040);
    check_eq("ready_psr",  32'(bus.CS_MICROSEQUENCER_PSR_OutBUS),  32'hF);
    bus.CS_MICROSEQUENCER_MIR_RD_In    = 1'b0;
    bus.CS_MICROSEQUENCER_ALU_SetCC_In = 1'b0;

    // Both RD and WR with zero-wait ready advance as one access
    bus.CS_MICROSEQUENCER_MIR_RD_In      = 1'b1;
    bus.CS_MICROSEQUENCER_MIR_WR_In      = 1'b1;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h041;
    #1 check_eq("zw_stall", 32'(bus.CS_MICROSEQUENCER_Stall_Out), 32'h0);
    step();
    check_eq("zw_csar", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h041);
    bus.CS_MICROSEQUENCER_MIR_RD_In  = 1'b0;
    bus.CS_MICROSEQUENCER_MIR_WR_In  = 1'b0;
    bus.CS_MICROSEQUENCER_MemReady_In = 1'b0;

`ifdef CS_MICROSEQUENCER_STALL_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES=4: four held edges, forced advance on the fifth
    check_eq("to_init", 32'(bus.CS_MICROSEQUENCER_Timeout_Out), 32'h0);
    bus.CS_MICROSEQUENCER_MIR_WR_In      = 1'b1;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h055;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("to_hold%0d", i), 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h041);
      check_eq($sformatf("to_flag%0d", i), 32'(bus.CS_MICROSEQUENCER_Timeout_Out), 32'h0);
    end
    check_eq("to_forced_stall", 32'(bus.CS_MICROSEQUENCER_Stall_Out), 32'h0);
    step();
    check_eq("to_csar",  32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h055);
    check_eq("to_set",   32'(bus.CS_MICROSEQUENCER_Timeout_Out), 32'h1);
    bus.CS_MICROSEQUENCER_MIR_WR_In      = 1'b0;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h056;
    step();
    step();
    check_eq("to_sticky", 32'(bus.CS_MICROSEQUENCER_Timeout_Out), 32'h1);
    check_eq("to_after_csar", 32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h056);
    rst_n = 1'b0;
    #1 check_eq("to_rst", 32'(bus.CS_MICROSEQUENCER_Timeout_Out), 32'h0);
    rst_n = 1'b1;
`else
    // Without the watchdog a stall never times out
    bus.CS_MICROSEQUENCER_MIR_WR_In      = 1'b1;
    bus.CS_MICROSEQUENCER_NextAddr_InBUS = 11'h055;
    for (int i = 0; i < 6; i++) step();
    check_eq("long_stall", 32'(bus.CS_MICROSEQUENCER_Stall_Out), 32'h1);
    check_eq("long_csar",  32'(bus.CS_MICROSEQUENCER_CSAR_OutBUS), 32'h041);
    bus.CS_MICROSEQUENCER_MIR_WR_In = 1'b0;
`endif

    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
